// File: rtl/brick_engine.sv
// Brick-breaker game-state engine: brick field, ball, paddle, BCD score and lives.
// Advances one game step per tick; every output comes straight from a register.
module brick_engine #(
    parameter int unsigned COLS       = 16,
    parameter int unsigned ROWS       = 12,
    parameter int unsigned BRICK_ROWS = 4,
    parameter int unsigned PADDLE_W   = 4,
    parameter int unsigned LIVES      = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       tick,
    input  logic                       move_left,
    input  logic                       move_right,
    input  logic                       start,
    output logic [BRICK_ROWS*COLS-1:0] bricks,
    output logic [$clog2(ROWS)-1:0]    ball_row,
    output logic [$clog2(COLS)-1:0]    ball_col,
    output logic [$clog2(COLS)-1:0]    paddle_pos,
    output logic [11:0]                score_bcd,
    output logic [2:0]                 lives,
    output logic [1:0]                 state
);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned NB = BRICK_ROWS * COLS;
    localparam int unsigned IW = $clog2(NB);

    localparam logic [CW-1:0] PadInit    = CW'((COLS - PADDLE_W) / 2);
    localparam logic [CW-1:0] PadMax     = CW'(COLS - PADDLE_W);
    localparam logic [CW-1:0] HalfW      = CW'(PADDLE_W / 2);
    localparam logic [CW-1:0] LastCol    = CW'(COLS - 1);
    localparam logic [RW-1:0] ServeRow   = RW'(ROWS - 2);
    localparam logic [RW-1:0] BrickRowsR = RW'(BRICK_ROWS);
    localparam logic [2:0]    LivesInit  = 3'(LIVES);

    typedef enum logic [1:0] {
        StServe = 2'd0,
        StPlay  = 2'd1,
        StOver  = 2'd2,
        StWin   = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [NB-1:0]   bricks_q, bricks_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [CW-1:0]   pad_q, pad_d;
    logic            dx_neg_q, dx_neg_d;
    logic            dy_up_q, dy_up_d;
    logic [11:0]     score_q, score_d;
    logic [2:0]      lives_q, lives_d;

    logic [CW-1:0]   pad_moved;
    logic            dx_neg_r, dy_up_r;
    logic [RW-1:0]   tgt_row;
    logic [CW-1:0]   tgt_col;
    logic [IW-1:0]   tgt_idx;
    logic            brick_hit, on_paddle;

    // Decimal ripple increment, saturating at 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] s);
        logic [11:0] r;
        logic        carry;
        r     = s;
        carry = 1'b1;
        if (s == 12'h999) return s;
        for (int d = 0; d < 3; d++) begin
            if (carry) begin
                if (r[4*d +: 4] == 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = r[4*d +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        pad_moved = pad_q;
        if (move_left && !move_right && pad_q != '0) begin
            pad_moved = pad_q - 1'b1;
        end else if (move_right && !move_left && pad_q < PadMax) begin
            pad_moved = pad_q + 1'b1;
        end

        dx_neg_r = dx_neg_q;
        if ((col_q == '0 && dx_neg_q) || (col_q == LastCol && !dx_neg_q)) dx_neg_r = !dx_neg_q;
        dy_up_r = dy_up_q;
        if (row_q == '0 && dy_up_q) dy_up_r = 1'b0;

        tgt_row   = dy_up_r ? row_q - 1'b1 : row_q + 1'b1;
        tgt_col   = dx_neg_r ? col_q - 1'b1 : col_q + 1'b1;
        tgt_idx   = IW'(32'(tgt_row) * COLS + 32'(tgt_col));
        brick_hit = (tgt_row < BrickRowsR) && bricks_q[tgt_idx];
        on_paddle = (tgt_col >= pad_q) &&
                    ({1'b0, tgt_col} <= {1'b0, pad_q} + (CW+1)'(PADDLE_W - 1));
    end

    always_comb begin
        state_d  = state_q;
        bricks_d = bricks_q;
        row_d    = row_q;
        col_d    = col_q;
        pad_d    = pad_q;
        dx_neg_d = dx_neg_q;
        dy_up_d  = dy_up_q;
        score_d  = score_q;
        lives_d  = lives_q;

        unique case (state_q)
            StServe: begin
                // start wins over tick: enter play without moving anything
                if (start) begin
                    state_d = StPlay;
                end else if (tick) begin
                    pad_d = pad_moved;
                end
                row_d    = ServeRow;
                col_d    = pad_d + HalfW;
                dx_neg_d = 1'b0;
                dy_up_d  = 1'b1;
            end
            StPlay: begin
                if (tick) begin
                    pad_d    = pad_moved;
                    dx_neg_d = dx_neg_r;
                    dy_up_d  = dy_up_r;
                    if (brick_hit) begin
                        bricks_d[tgt_idx] = 1'b0;
                        score_d           = bcd_inc(score_q);
                        dy_up_d           = !dy_up_r;
                        if (bricks_d == '0) state_d = StWin;
                    end else if (row_q == ServeRow && !dy_up_r) begin
                        if (on_paddle) begin
                            dy_up_d = 1'b1;
                        end else begin
                            lives_d = lives_q - 3'd1;
                            if (lives_q == 3'd1) begin
                                state_d = StOver;
                            end else begin
                                state_d  = StServe;
                                row_d    = ServeRow;
                                col_d    = pad_moved + HalfW;
                                dx_neg_d = 1'b0;
                                dy_up_d  = 1'b1;
                            end
                        end
                    end else begin
                        row_d = tgt_row;
                        col_d = tgt_col;
                    end
                end
            end
            StOver, StWin: begin
                if (start) begin
                    state_d  = StServe;
                    bricks_d = '1;
                    row_d    = ServeRow;
                    col_d    = PadInit + HalfW;
                    pad_d    = PadInit;
                    dx_neg_d = 1'b0;
                    dy_up_d  = 1'b1;
                    score_d  = '0;
                    lives_d  = LivesInit;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StServe;
            bricks_q <= '1;
            row_q    <= ServeRow;
            col_q    <= PadInit + HalfW;
            pad_q    <= PadInit;
            dx_neg_q <= 1'b0;
            dy_up_q  <= 1'b1;
            score_q  <= '0;
            lives_q  <= LivesInit;
        end else begin
            state_q  <= state_d;
            bricks_q <= bricks_d;
            row_q    <= row_d;
            col_q    <= col_d;
            pad_q    <= pad_d;
            dx_neg_q <= dx_neg_d;
            dy_up_q  <= dy_up_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
        end
    end

    assign bricks     = bricks_q;
    assign ball_row   = row_q;
    assign ball_col   = col_q;
    assign paddle_pos = pad_q;
    assign score_bcd  = score_q;
    assign lives      = lives_q;
    assign state      = state_q;

endmodule

// File: tb/tb_brick_engine.sv
// Bench for brick_engine (default parameters): random and directed play against
// an integer game model that tracks positions, +/-1 directions and a decimal score.
module tb_brick_engine;
    localparam int COLS  = 16;
    localparam int ROWS  = 12;
    localparam int BR    = 4;
    localparam int PW    = 4;
    localparam int LIVES = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0, move_left = 1'b0, move_right = 1'b0, start = 1'b0;
    logic [63:0] bricks;
    logic [3:0]  ball_row, ball_col, paddle_pos;
    logic [11:0] score_bcd;
    logic [2:0]  lives;
    logic [1:0]  state;
    logic [92:0] obs;

    int checks = 0;
    int errors = 0;

    int          m_state, m_row, m_col, m_dx, m_dy, m_pad, m_score, m_lives;
    logic [63:0] m_bricks;

    brick_engine dut (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .move_left  (move_left),
        .move_right (move_right),
        .start      (start),
        .bricks     (bricks),
        .ball_row   (ball_row),
        .ball_col   (ball_col),
        .paddle_pos (paddle_pos),
        .score_bcd  (score_bcd),
        .lives      (lives),
        .state      (state)
    );

    assign obs = {bricks, ball_row, ball_col, paddle_pos, score_bcd, lives, state};

    always #5 clock = ~clock;

    function automatic logic [11:0] to_bcd(input int s);
        return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic logic [92:0] exp_vec();
        return {m_bricks, 4'(m_row), 4'(m_col), 4'(m_pad), to_bcd(m_score), 3'(m_lives),
                2'(m_state)};
    endfunction

    task automatic model_init();
        m_state  = 0;
        m_bricks = '1;
        m_pad    = (COLS - PW) / 2;
        m_row    = ROWS - 2;
        m_col    = m_pad + PW / 2;
        m_dx     = 1;
        m_dy     = -1;
        m_score  = 0;
        m_lives  = LIVES;
    endtask

    task automatic model_update(input bit t, input bit l, input bit r, input bit s,
                                input bit rst);
        int np, op, tr, tc;
        logic [5:0] bi;
        if (rst) begin model_init(); return; end
        if (m_state >= 2) begin
            if (s) model_init();
            return;
        end
        np = m_pad;
        if (t && l && !r && m_pad > 0) np = m_pad - 1;
        if (t && r && !l && m_pad < COLS - PW) np = m_pad + 1;
        if (m_state == 0) begin
            if (s) m_state = 1;
            else m_pad = np;
            m_row = ROWS - 2;
            m_col = m_pad + PW / 2;
            m_dx  = 1;
            m_dy  = -1;
            return;
        end
        if (!t) return;
        if ((m_col == 0 && m_dx < 0) || (m_col == COLS - 1 && m_dx > 0)) m_dx = -m_dx;
        if (m_row == 0 && m_dy < 0) m_dy = -m_dy;
        tr    = m_row + m_dy;
        tc    = m_col + m_dx;
        bi    = 6'(tr * COLS + tc);
        op    = m_pad;
        m_pad = np;
        if (tr < BR && m_bricks[bi]) begin
            m_bricks[bi] = 1'b0;
            if (m_score < 999) m_score++;
            m_dy = -m_dy;
            if (m_bricks == 64'd0) m_state = 3;
        end else if (m_row == ROWS - 2 && m_dy > 0) begin
            if (tc >= op && tc < op + PW) begin
                m_dy = -m_dy;
            end else begin
                m_lives--;
                if (m_lives == 0) begin
                    m_state = 2;
                end else begin
                    m_state = 0;
                    m_row   = ROWS - 2;
                    m_col   = m_pad + PW / 2;
                    m_dx    = 1;
                    m_dy    = -1;
                end
            end
        end else begin
            m_row = tr;
            m_col = tc;
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, settle 1 time unit past it.
    task automatic step(input bit t, input bit l, input bit r, input bit s);
        tick = t; move_left = l; move_right = r; start = s;
        @(posedge clock);
        model_update(t, l, r, s, reset);
        #1;
        tick = 1'b0; move_left = 1'b0; move_right = 1'b0; start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b1);
        reset = 1'b0;
    endtask

    // Steer toward the ball (track=1) or away from it (track=0).
    task automatic pilot(input bit track, output bit l, output bit r);
        int target, center;
        target = track ? m_col : (m_col < COLS / 2 ? COLS - 1 : 0);
        center = m_pad + PW / 2;
        l = target < center;
        r = target > center;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        checks++;
        if (bricks !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL reset_bricks got %h exp all ones", bricks);
        end
        checks++;
        if (paddle_pos !== 4'd6) begin
            errors++; $display("FAIL reset_paddle got %0d exp 6", paddle_pos);
        end
        checks++;
        if ({ball_row, ball_col} !== {4'd10, 4'd8}) begin
            errors++; $display("FAIL reset_ball got (%0d,%0d) exp (10,8)", ball_row, ball_col);
        end
        checks++;
        if ({lives, score_bcd, state} !== {3'd3, 12'h000, 2'd0}) begin
            errors++;
            $display("FAIL reset_misc got lives %0d score %h state %0d exp 3 000 0",
                     lives, score_bcd, state);
        end
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("FAIL reset_model got %h exp %h", obs, exp_vec());
        end
    endtask

    task automatic test_paddle_limits();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (paddle_pos !== 4'd0) begin
            errors++; $display("FAIL paddle_left got %0d exp 0", paddle_pos);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (paddle_pos !== 4'd0) begin
            errors++; $display("FAIL paddle_both got %0d exp 0", paddle_pos);
        end
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (paddle_pos !== 4'd12) begin
            errors++; $display("FAIL paddle_right got %0d exp 12", paddle_pos);
        end
        checks++;
        if ({ball_row, ball_col} !== {4'd10, 4'd14}) begin
            errors++; $display("FAIL serve_track got (%0d,%0d) exp (10,14)", ball_row, ball_col);
        end
    endtask

    task automatic test_start_precedence();
        step(1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({state, paddle_pos, ball_row, ball_col} !== {2'd1, 4'd12, 4'd10, 4'd14}) begin
            errors++;
            $display("FAIL start_tick got st %0d pad %0d ball (%0d,%0d) exp 1 12 (10,14)",
                     state, paddle_pos, ball_row, ball_col);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({ball_row, ball_col} !== {4'd9, 4'd15}) begin
            errors++; $display("FAIL first_step got (%0d,%0d) exp (9,15)", ball_row, ball_col);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs !== exp_vec() || state !== 2'd1) begin
            errors++; $display("FAIL start_in_play got %h exp %h", obs, exp_vec());
        end
    endtask

    task automatic test_random_play();
        bit l, r;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1) == 1) pilot(1'b1, l, r);
            else begin l = 1'($urandom); r = 1'($urandom); end
            reset = ($urandom_range(0, 399) == 0);
            step(1'($urandom), l, r, ($urandom_range(0, 15) == 0));
            reset = 1'b0;
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL random cyc %0d got %h exp %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_miss_over();
        bit l, r;
        int prev_lives, fr, fc, fp;
        do_reset();
        for (int i = 0; i < 3000 && m_state != 2; i++) begin
            prev_lives = m_lives;
            pilot(1'b0, l, r);
            if (m_state == 0) step(1'b0, 1'b0, 1'b0, 1'b1);
            else step(1'b1, l, r, 1'b0);
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL miss_cyc %0d got %h exp %h", i, obs, exp_vec());
            end
            if (m_lives < prev_lives && m_lives > 0) begin
                checks++;
                if ({state, ball_row, ball_col} !== {2'd0, 4'd10, 4'(m_pad + PW / 2)}) begin
                    errors++;
                    $display("FAIL miss_repark got st %0d (%0d,%0d) exp 0 (10,%0d)",
                             state, ball_row, ball_col, m_pad + PW / 2);
                end
            end
        end
        checks++;
        if (m_state != 2 || state !== 2'd2 || lives !== 3'd0) begin
            errors++;
            $display("FAIL over_reach got st %0d lives %0d exp 2 0", state, lives);
        end
        fr = m_row; fc = m_col; fp = m_pad;
        for (int i = 0; i < 5; i++) step(1'b1, i[0], !i[0], 1'b0);
        checks++;
        if ({ball_row, ball_col, paddle_pos, state} !== {4'(fr), 4'(fc), 4'(fp), 2'd2}) begin
            errors++;
            $display("FAIL over_frozen got (%0d,%0d) pad %0d st %0d exp (%0d,%0d) pad %0d st 2",
                     ball_row, ball_col, paddle_pos, state, fr, fc, fp);
        end
    endtask

    task automatic test_win_restart();
        bit l, r;
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        force dut.bricks_q = 64'h8000_0000_0000_0000;
        m_bricks = 64'h8000_0000_0000_0000;
        #1 release dut.bricks_q;
        for (int i = 0; i < 300 && m_state != 3; i++) begin
            pilot(1'b1, l, r);
            step(1'b1, l, r, m_state == 0);
        end
        checks++;
        if ({state, bricks, score_bcd} !== {2'd3, 64'd0, 12'h001}) begin
            errors++;
            $display("FAIL win got st %0d bricks %h score %h exp 3 0 001", state, bricks, score_bcd);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("FAIL win_frozen got %h exp %h", obs, exp_vec());
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({state, bricks, paddle_pos, ball_row, ball_col, score_bcd, lives} !==
            {2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd6, 4'd10, 4'd8, 12'h000, 3'd3}) begin
            errors++; $display("FAIL restart got %h exp %h", obs, exp_vec());
        end
    endtask

    task automatic test_saturation();
        bit l, r;
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        force dut.score_q = 12'h999;
        m_score = 999;
        #1 release dut.score_q;
        for (int i = 0; i < 300 && m_bricks == '1; i++) begin
            pilot(1'b1, l, r);
            step(1'b1, l, r, m_state == 0);
        end
        checks++;
        if (score_bcd !== 12'h999 || bricks === 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL score_sat got score %h bricks %h exp 999 with a cleared brick",
                     score_bcd, bricks);
        end
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("FAIL sat_model got %h exp %h", obs, exp_vec());
        end
    endtask

    initial begin
        model_init();
        #2;
        test_reset();
        test_paddle_limits();
        test_start_precedence();
        test_random_play();
        test_miss_over();
        test_win_restart();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/brick_engine.md
# brick_engine

Parametrised game-state engine for the brick-breaker design. It owns the brick field, ball, paddle, BCD score and lives, and advances one game step per `tick` strobe. Field size, brick depth, paddle width and life count are generics. Unlike the fixed 16-column core, it adds multi-life serving, win detection and a restart flow, and drives render/score logic from registered state.

## Interface
- `COLS`, default 16: field width in cells, 8..32.
- `ROWS`, default 12: field height in cells. Row 0 is the top; the paddle occupies row ROWS-1.
- `BRICK_ROWS`, default 4: brick rows 0..BRICK_ROWS-1. BRICK_ROWS ≤ ROWS-3.
- `PADDLE_W`, default 4: paddle width in cells, 2..COLS-1.
- `LIVES`, default 3: lives loaded at reset/restart, 1..7.
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `tick` in 1: one-cycle game-step strobe.
- `move_left`, `move_right` in 1: paddle requests, sampled on tick cycles.
- `start` in 1: serve/restart request, sampled every cycle.
- `bricks` out BRICK_ROWS*COLS: bit r*COLS+c = brick at (r,c).
- `ball_row` out $clog2(ROWS); `ball_col` out $clog2(COLS).
- `paddle_pos` out $clog2(COLS): leftmost paddle cell.
- `score_bcd` out 12: three BCD digits, [11:8] hundreds.
- `lives` out 3.
- `state` out 2: 0 SERVE, 1 PLAY, 2 OVER, 3 WIN.

## Operation
- Reset and restart initialise the same values:
  - State SERVE; `bricks` all ones; `score_bcd` 0; `lives`=LIVES.
  - `paddle_pos`=(COLS-PADDLE_W)/2; direction dx=+1, dy=-1.
  - Ball at row ROWS-2, col paddle_pos+PADDLE_W/2.
- Paddle update, on tick cycles in SERVE or PLAY only:
  - `move_left` only, and pos>0: decrement.
  - `move_right` only, and pos<COLS-PADDLE_W: increment.
  - Both or neither asserted: hold.
- SERVE:
  - Ball tracks the paddle every cycle: col = paddle_pos+PADDLE_W/2, row ROWS-2, dx=+1, dy=-1.
  - `start` → PLAY.
- PLAY, on each tick, evaluated in this order against pre-tick ball and paddle values:
  1. Side wall: col=0 with dx=-1, or col=COLS-1 with dx=+1 → negate dx.
  2. Top wall: row=0 with dy=-1 → negate dy.
  3. Brick: target cell (row+dy, col+dx), using post-reflection directions. If it holds a brick: clear that bit, score +1, negate dy, ball does not move.
  4. Paddle: row=ROWS-2 with dy=+1. If col+dx lies in [paddle_pos, paddle_pos+PADDLE_W-1]: negate dy, ball does not move. Otherwise it is a miss.
  5. Otherwise the ball moves to the target cell.
- Miss:
  - Decrement lives.
  - If lives becomes 0 → OVER; the ball holds its position.
  - Else → SERVE, with the ball re-parked on the paddle.
- Win: the clearing of the last brick bit → WIN, in the same cycle as the clear.
- OVER / WIN:
  - All state frozen; tick and move requests are ignored.
  - `start` → full restart: everything reinitialised as at reset, state SERVE.
- Score is BCD with ripple carry and saturates at 999; no binary intermediate.

## Timing
- All outputs are registered and update on the clock edge that samples their cause. No combinational input-to-output path.
- One tick produces exactly one PLAY step; ball latency is 1 cycle from the tick.
- `start` in SERVE takes precedence over `tick` in the same cycle:
  - State → PLAY.
  - The paddle does not move and the ball is not stepped.
  - The first step occurs on the next tick.
- `start` in PLAY is ignored.
- `reset` overrides everything in any state, including mid-tick. Values are as listed under Operation one cycle after reset is sampled high.
- Brick clear, score increment and WIN transition are visible together on the same edge.
- Corner case: side and top reflection may both apply in one tick; the brick check then uses the doubly-reflected target.

## Test plan
- Reset with default parameters:
  - `bricks`=64'hFFFF_FFFF_FFFF_FFFF, `paddle_pos`=6, ball (10,8), `lives`=3, `score_bcd`=0, `state`=0.
- Paddle limits:
  - 10 ticks with `move_left` held → `paddle_pos`=0.
  - Both moves asserted for 1 tick → stays 0.
  - 20 ticks with `move_right` held → 12.
- Brick hit from (4,5), dx=+1, dy=-1, brick (3,6) present:
  - After 1 tick: bit 54 cleared, score 001, dy=+1, ball still at (4,5).
- Miss at (10,15) with dy=+1 and `paddle_pos`=0:
  - After 1 tick: `lives` 3→2, state SERVE, ball (10,2).
  - Repeat until `lives`=0 → state OVER, ball frozen under further ticks.
- Win: with one brick left, hit it:
  - state WIN, `bricks`=0, score incremented.
  - Then `start` → full reinit, state SERVE.
- Saturation and precedence:
  - Preload score 999 and hit a brick → stays 999.
  - `start` with `tick` in SERVE → PLAY, ball unmoved.
